bcd2bin_seq: RTL and testbench
==============================

# bcd2bin_seq

Sequential BCD-to-binary converter, the inverse of the team's combinational binary-to-BCD decoder. Accepts an NDIG-digit packed BCD word over a valid/ready handshake and converts it one bit per cycle using the reverse double-dabble method: shift right, then subtract 3 from each digit ≥ 8. Presents the binary result on a held valid/ready output port. Sits between BCD-producing front ends (keypad/display logic) and binary datapaths.

## Interface
- NDIG, 2, number of BCD digits (1..4)
- BIN_W, 7, result width; must satisfy 2^BIN_W ≥ 10^NDIG (7 for NDIG=2)
- clk  input  1  clock, rising-edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  in_bcd valid
- in_ready  output  1  converter can accept; high only in IDLE
- in_bcd  input  4*NDIG  packed BCD, digit 0 in [3:0]
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  downstream accepts result
- out_bin  output  BIN_W  binary result
- out_err  output  1  input contained a digit > 9 (see Configuration)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, load the shift register {bcd=in_bcd, bin=0}, clear the iteration counter, and go to SHIFT.
- SHIFT: each cycle, shift the {bcd,bin} register right by 1 (bcd LSB enters bin MSB), then for every digit with value ≥ 8, subtract 3 (4-bit, no borrow across digits). The counter increments. After BIN_W iterations, go to DONE.
- DONE: out_valid=1. out_bin and out_err are stable. On out_ready, go to IDLE. No new input is accepted in SHIFT or DONE.
- All arithmetic is per-digit 4-bit. The result is exact for valid inputs 0..10^NDIG-1.
- No pipelining: one conversion in flight.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0, counter=0.
- Latency: out_valid rises exactly BIN_W cycles after the input handshake edge (7 for defaults).
- The earliest next acceptance is the cycle after the output handshake. Back-to-back period is BIN_W+2 cycles.
- out_bin and out_err may change only on the edge leaving SHIFT. They are held through DONE regardless of out_ready.
- in_valid during SHIFT/DONE is ignored. The source holds in_bcd until its own handshake.
- rst_n asserted mid-conversion aborts immediately (asynchronously) to reset values. The partial result is discarded.
- in_ready is decoded from state only, with no combinational path from in_valid. out_valid is likewise decoded from state only.

## Configuration
- BCD2BIN_ERR_CHECK_EN defined:
  - At load, any digit > 9 is registered as an error flag.
  - In DONE, out_err=1 and out_bin is forced to 0.
  - Latency is unchanged.
- Undefined:
  - out_err is tied to 0.
  - Invalid digits run through the algorithm unchanged; out_bin is unspecified and not checked.

## Structure
- Package bcd_pkg holds:
  - state enum type (IDLE/SHIFT/DONE)
  - DIGIT_W=4, DIGIT_MAX=9, ADJ_THRESH=8, ADJ_SUB=3
  - helper function for the BIN_W-from-NDIG sanity check
- Sub-module bcd_digit_adj: combinational, 4-bit in/out. Outputs in-3 if in ≥ 8, else in. Instantiated NDIG times via generate.
- Top contains the FSM, counter ($clog2(BIN_W+1) bits), shift register and error flag.

## Test plan
- Reset, then in_bcd=8'h00 -> out_valid exactly 7 cycles after acceptance, out_bin=0, out_err=0.
- in_bcd=8'h15, then 8'h99 with out_ready=1 -> out_bin=15, then 99. in_ready returns high one cycle after each output handshake.
- in_bcd=8'h42, out_ready held 0 for 5 cycles, with in_valid and 8'h07 applied meanwhile -> out_bin=42 held, in_ready=0. 8'h07 is accepted only after the handshake and yields 7.
- in_bcd=8'h1A -> with BCD2BIN_ERR_CHECK_EN: out_err=1, out_bin=0. Without it: out_err=0.
- in_bcd=8'h57, rst_n pulsed low on the 3rd SHIFT cycle -> out_valid=0 and in_ready=1 immediately. Next 8'h23 -> out_bin=23.
- Sweep all 0..99 back-to-back with randomized out_ready -> every out_bin equals its decimal value, in order.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types, digit constants and parameter sanity helper for
//            the sequential BCD-to-binary converter.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                   DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0]   DIGIT_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0]   ADJ_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0]   ADJ_SUB    = 4'd3;

    // True when a BIN_W-bit result can hold every NDIG-digit decimal value.
    function automatic bit bin_w_ok(input int ndig, input int bin_w);
        longint p2;
        longint p10;
        p2  = 1;
        p10 = 1;
        for (int i = 0; i < bin_w; i++) p2 = p2 * 2;
        for (int i = 0; i < ndig; i++) p10 = p10 * 10;
        return (p2 >= p10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2bin_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd2bin_seq_if
// Brief    : Input (BCD) and output (binary) valid/ready channels of the
//            BCD-to-binary converter.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd2bin_seq_if #(
    parameter int NDIG  = 2,
    parameter int BIN_W = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [4*NDIG-1:0] in_bcd;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  out_bin;
    logic              out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Reverse double-dabble digit correction: subtract 3 when >= 8.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  wire logic [DIGIT_W-1:0] i_digit,
    output logic      [DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit - ADJ_SUB) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd2bin_seq
// Brief    : Sequential BCD-to-binary converter, one result bit per cycle.
//            Optional digit range check enabled by BCD2BIN_ERR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIG  = 2,
    parameter int BIN_W = 7
) (
    input  wire          clk,
    input  wire          rst_n,
    bcd2bin_seq_if.slave bus
);

    localparam int                 c_BCD_W = DIGIT_W * NDIG;
    localparam int                 c_CNT_W = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BIN_W - 1);

    if (!bin_w_ok(NDIG, BIN_W) || NDIG < 1 || NDIG > 4) begin : g_bad_param
        $error("bcd2bin_seq: BIN_W too small for NDIG or NDIG out of range");
    end

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_BCD_W-1:0]   w_shift_bcd;
    logic [c_BCD_W-1:0]   w_adj_bcd;
    // The LSB shifted out of the accumulator is never needed, so only the
    // upper BIN_W-1 bits are kept; the last shift lands directly in r_res.
    logic [BIN_W-2:0]     r_acc;
    logic [BIN_W-1:0]     w_shift_bin;
    logic [BIN_W-1:0]     w_res_bin;
    logic [BIN_W-1:0]     r_res;
    logic                 w_load;
    logic                 w_last;

    assign w_load      = (r_state == IDLE) && bus.in_valid;
    assign w_last      = (r_state == SHIFT) && (r_cnt == c_LAST);
    assign w_shift_bcd = {1'b0, r_bcd[c_BCD_W-1:1]};
    assign w_shift_bin = {r_bcd[0], r_acc};

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (w_shift_bcd[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_adj_bcd[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)     w_next = SHIFT;
            SHIFT:   if (r_cnt == c_LAST)  w_next = DONE;
            DONE:    if (bus.out_ready)    w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_bcd <= '0;
            r_acc <= '0;
            r_res <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
            r_bcd <= bus.in_bcd;
            r_acc <= '0;
        end else if (r_state == SHIFT) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
            r_bcd <= w_adj_bcd;
            r_acc <= w_shift_bin[BIN_W-1:1];
            if (w_last) r_res <= w_res_bin;
        end
    end

`ifdef BCD2BIN_ERR_CHECK_EN
    logic r_err;
    logic r_res_err;
    logic w_bad;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.in_bcd[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) w_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_res_err <= 1'b0;
        end else begin
            if (w_load) r_err     <= w_bad;
            if (w_last) r_res_err <= r_err;
        end
    end

    assign w_res_bin   = r_err ? '0 : w_shift_bin;
    assign bus.out_err = r_res_err;
`else
    assign w_res_bin   = w_shift_bin;
    assign bus.out_err = 1'b0;
`endif

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_bin   = r_res;

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd2bin_seq
// Brief    : Self-checking bench for bcd2bin_seq (NDIG=2, BIN_W=7).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd2bin_seq;

    localparam int NDIG  = 2;
    localparam int BIN_W = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd2bin_seq_if #(.NDIG(NDIG), .BIN_W(BIN_W)) bus ();

    bcd2bin_seq #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [BIN_W-1:0] last_bin;
    bit               last_known;

    typedef struct {
        logic [7:0]       bcd;
        logic [BIN_W-1:0] exp_bin;
        logic             exp_err;
    } vec_t;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] b;
        b[7:4] = 4'(v / 10);
        b[3:0] = 4'(v % 10);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid after an input handshake; out_bin must not move while shifting.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            if (last_known) check("bin_stable_shift", bus.out_bin, last_bin);
            check("in_ready_busy", bus.in_ready, 0);
            tick();
            cyc++;
        end
    endtask

    task automatic convert(input logic [7:0] bcd, input int hold, input bit chk_bin,
                           input logic [BIN_W-1:0] exp_bin, input logic exp_err);
        int cyc;
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_bcd   = bcd;
        tick();
        bus.in_valid = 1'b0;
        bus.in_bcd   = 8'($urandom);
        wait_valid(cyc);
        check("latency", cyc, BIN_W);
        if (chk_bin) check("out_bin", bus.out_bin, exp_bin);
        check("out_err", bus.out_err, exp_err);
        last_bin   = exp_bin;
        last_known = chk_bin;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("valid_held", bus.out_valid, 1);
            check("in_ready_done", bus.in_ready, 0);
            if (chk_bin) check("bin_held", bus.out_bin, exp_bin);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("in_ready_after", bus.in_ready, 1);
        check("valid_dropped", bus.out_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   cyc;
        int   v;

        vecs[0] = '{8'h00, 7'd0,  1'b0};
        vecs[1] = '{8'h15, 7'd15, 1'b0};
        vecs[2] = '{8'h99, 7'd99, 1'b0};
        vecs[3] = '{8'h01, 7'd1,  1'b0};
        vecs[4] = '{8'h09, 7'd9,  1'b0};
        vecs[5] = '{8'h10, 7'd10, 1'b0};
        vecs[6] = '{8'h50, 7'd50, 1'b0};
        vecs[7] = '{8'h87, 7'd87, 1'b0};
        vecs[8] = '{8'h38, 7'd38, 1'b0};
        vecs[9] = '{8'h64, 7'd64, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b0;
        last_bin      = '0;
        last_known    = 1'b1;

        rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_bin", bus.out_bin, 0);
        check("rst_out_err", bus.out_err, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].bcd, (i % 3), 1'b1, vecs[i].exp_bin, vecs[i].exp_err);
        end

        // 42 held in DONE while 07 is offered; 07 only enters after the output handshake.
        bus.in_valid = 1'b1;
        bus.in_bcd   = 8'h42;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(cyc);
        check("latency_42", cyc, BIN_W);
        check("out_bin_42", bus.out_bin, 42);
        bus.in_valid = 1'b1;
        bus.in_bcd   = 8'h07;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("in_ready_blocked", bus.in_ready, 0);
            check("out_valid_42", bus.out_valid, 1);
            check("out_bin_42_held", bus.out_bin, 42);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("in_ready_after_42", bus.in_ready, 1);
        check("out_bin_42_idle", bus.out_bin, 42);
        tick();
        bus.in_valid = 1'b0;
        last_bin = 7'd42;
        wait_valid(cyc);
        check("latency_07", cyc, BIN_W);
        check("out_bin_07", bus.out_bin, 7);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        last_bin = 7'd7;

        // Invalid low digit.
`ifdef BCD2BIN_ERR_CHECK_EN
        convert(8'h1A, 1, 1'b1, 7'd0, 1'b1);
`else
        convert(8'h1A, 1, 1'b0, 7'd0, 1'b0);
`endif

        // Asynchronous abort on the third SHIFT cycle.
        bus.in_valid = 1'b1;
        bus.in_bcd   = 8'h57;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_out_bin", bus.out_bin, 0);
        check("abort_out_err", bus.out_err, 0);
        tick();
        rst_n = 1'b1;
        last_bin   = '0;
        last_known = 1'b1;
        tick();
        convert(8'h23, 0, 1'b1, 7'd23, 1'b0);

        // Full sweep in order with random downstream stalls.
        for (int n = 0; n < 100; n++) begin
            convert(to_bcd(n), int'($urandom_range(0, 3)), 1'b1, 7'(n), 1'b0);
        end

        // Random valid values against the decimal model.
        for (int n = 0; n < 30; n++) begin
            v = int'($urandom_range(0, 99));
            convert(to_bcd(v), int'($urandom_range(0, 2)), 1'b1, 7'(v), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
